reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Parametrised successor to the single-channel 40 MHz reset synchronizer.
- Merges N_REQ asynchronous active-low reset requests and a software reset pulse.
- Filters and stretches the merged reset, then releases N_CH active-low reset outputs one after another in index order, with programmable spacing.
- Sits at the top of the fast-control clock domain and drives the decoder, the counters and the loopback logic.

Parameters:
N_REQ, 2, number of asynchronous active-low reset request inputs (1..8)
N_CH, 3, number of sequenced active-low reset outputs (1..16)
SYNC_STAGES, 2, synchroniser flops per request bit (2..4)
MIN_PULSE, 2, minimum synchronised request width in cycles that is accepted as a reset (1..15)
HOLD_CYCLES, 4, cycles all outputs stay asserted after the last reset source goes inactive (1..65535)
STEP_CYCLES, 2, cycles between releasing consecutive channels (1..65535)

Ports:
clk  in  1  fast-control clock (40 MHz)
reset  in  1  master reset, synchronous, active-high
rst_req_b  in  N_REQ  asynchronous reset requests, active-low
sw_rst  in  1  synchronous software reset, single-cycle pulse, active-high
cause_clr  in  1  synchronous pulse that clears rst_cause
rst_out_b  out  N_CH  sequenced resets, active-low; bit 0 is released first
all_released  out  1  high when every rst_out_b bit is 1
busy  out  1  high when the FSM is not in DONE
rst_cause  out  N_REQ+1  sticky record of reset sources; bits [N_REQ-1:0] are requests, bit N_REQ is sw_rst

Behaviour:
- One clock. Reset is synchronous and active-high. All state is sampled on the rising edge of clk.
- Values forced while reset=1:
  - rst_out_b = 0, all_released = 0, busy = 1, rst_cause = 0
  - FSM = ASSERT, hold counter = 0, step counter = 0, channel index = 0
  - synchroniser flops = 1 (inactive), so releasing reset adds no extra SYNC_STAGES delay.
- Synchroniser: each rst_req_b bit passes through SYNC_STAGES flops.
- Pulse filter: one saturating width counter per request bit. req_valid[i] goes high once the synchronised bit has been low for MIN_PULSE consecutive cycles. It stays high while the bit stays low and drops on the first cycle the bit is high again. Shorter pulses are ignored.
- Latency from a rst_req_b falling edge to the rst_out_b falling edge is SYNC_STAGES+MIN_PULSE cycles, ±1 cycle for the asynchronous sample point. For sw_rst the rst_out_b falling edge follows the pulse edge by one cycle.
- src_active = OR of req_valid, OR sw_rst.
- FSM states ASSERT, RELEASE, DONE:
  - ASSERT: rst_out_b = 0. The hold counter resets to 0 on every cycle with src_active=1; otherwise it increments. When hold count reaches HOLD_CYCLES-1 with src_active=0: drive rst_out_b[0]=1, set channel index to 1, go to RELEASE, or to DONE if N_CH=1.
  - RELEASE: the step counter increments each cycle. When it reaches STEP_CYCLES-1: drive rst_out_b[index]=1, increment the index, clear the step counter. After releasing bit N_CH-1, go to DONE.
  - DONE: all rst_out_b = 1, all_released = 1, busy = 0.
  - src_active=1 in any state: go to ASSERT. All rst_out_b = 0 on the next edge, and all counters and the index are cleared.
- Timing reference: take edge 1 as the first edge with reset=0, with no request active. rst_out_b[k] then rises at edge HOLD_CYCLES + k*STEP_CYCLES. all_released rises on the same edge as rst_out_b[N_CH-1].
- Simultaneous events:
  - reset has priority over everything.
  - sw_rst or a request arriving on the same edge as a scheduled release: the reassert wins and the release does not happen.
  - cause_clr on the same edge as a new source: the new cause bit is set, and bits not being set are cleared.
- rst_cause: bit i is set on the first cycle of a req_valid[i] rising edge, and bit N_REQ on sw_rst. Bits are cleared only by cause_clr or reset.
- Counter widths: $clog2(max(HOLD_CYCLES,STEP_CYCLES)+1) for the hold and step counters, $clog2(MIN_PULSE+1) for each filter counter. Counters saturate and never wrap.
- Outputs are registered, with no combinational path from inputs to rst_out_b.

Decomposition:
- Package reset_seq_pkg holds:
  - the FSM enum (ASSERT, RELEASE, DONE)
  - the parameter defaults
  - a function returning the counter widths
- Parameter range checks are elaboration-time assertions in the top module.
- Sub-module reset_req_filter holds one request bit's synchroniser chain plus its MIN_PULSE filter, outputting req_valid. It is instantiated N_REQ times via generate.

Test Plan:
1. Power-up (defaults), hold reset for 5 cycles, then release with no requests -> rst_out_b steps 000→001 at edge 4, →011 at edge 6, →111 at edge 8; all_released and busy=0 at edge 8; rst_cause=0.
2. In DONE, pull rst_req_b[1] low for 1 cycle -> filtered; outputs stay 111 and rst_cause stays 000.
3. In DONE, pull rst_req_b[0] low for 6 cycles -> rst_out_b=000 at SYNC_STAGES+MIN_PULSE (=4, ±1) cycles after the fall; after release, the 4/6/8 sequence restarts from the request going inactive; rst_cause=001.
4. sw_rst pulse on the same edge as the scheduled rst_out_b[1] release -> bit 1 is not released, all outputs 000, hold restarts; rst_cause[2]=1.
5. Assert reset mid-RELEASE (rst_out_b=001) -> next edge rst_out_b=000, rst_cause=0, busy=1, synchroniser flops 1.
6. HOLD_CYCLES=1, STEP_CYCLES=1, N_CH=1 -> rst_out_b[0] and all_released rise at edge 1; cause_clr together with a new sw_rst leaves only bit N_REQ set.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared FSM state type, parameter defaults and counter sizing for the reset sequencer
package reset_seq_pkg;
  typedef enum logic [1:0] {ASSERT, RELEASE, DONE} seq_state_e;
  localparam int N_REQ_DEF = 2;
  localparam int N_CH_DEF = 3;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int MIN_PULSE_DEF = 2;
  localparam int HOLD_CYCLES_DEF = 4;
  localparam int STEP_CYCLES_DEF = 2;
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/reset_req_filter.sv
// reset_req_filter: synchronises one active-low reset request and accepts it only after MIN_PULSE low cycles
module reset_req_filter
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int MIN_PULSE = MIN_PULSE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic req_b,
  output logic req_valid
);
  localparam int CW = cnt_width(MIN_PULSE, 0);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (reset) begin
      sync <= '1;
      cnt <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], req_b};
      cnt <= sync[SYNC_STAGES-1] ? '0 : (cnt == CW'(MIN_PULSE - 1) ? cnt : cnt + 1'b1);
    end
  // Valid on the MIN_PULSE-th low cycle and dropped as soon as the synchronised bit returns high
  assign req_valid = !sync[SYNC_STAGES-1] && cnt == CW'(MIN_PULSE - 1);
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: merges filtered reset requests and sw_rst, then releases N_CH resets in index order
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int N_CH = N_CH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int MIN_PULSE = MIN_PULSE_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int STEP_CYCLES = STEP_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] rst_req_b,
  input  logic             sw_rst,
  input  logic             cause_clr,
  output logic [N_CH-1:0]  rst_out_b,
  output logic             all_released,
  output logic             busy,
  output logic [N_REQ:0]   rst_cause
);
  localparam int CW = cnt_width(HOLD_CYCLES, STEP_CYCLES);
  localparam int IW = $clog2(N_CH + 1);
  if (N_REQ < 1 || N_REQ > 8) begin : g_bad_n_req
    $error("reset_sequencer: N_REQ out of range 1..8");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
    $error("reset_sequencer: N_CH out of range 1..16");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("reset_sequencer: SYNC_STAGES out of range 2..4");
  end
  if (MIN_PULSE < 1 || MIN_PULSE > 15) begin : g_bad_pulse
    $error("reset_sequencer: MIN_PULSE out of range 1..15");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES out of range 1..65535");
  end
  if (STEP_CYCLES < 1 || STEP_CYCLES > 65535) begin : g_bad_step
    $error("reset_sequencer: STEP_CYCLES out of range 1..65535");
  end
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_valid_q;
  logic src_active;
  seq_state_e state;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] step_cnt;
  logic [IW-1:0] idx;
  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    reset_req_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .MIN_PULSE(MIN_PULSE)
    ) u_filter (
      .clk(clk),
      .reset(reset),
      .req_b(rst_req_b[i]),
      .req_valid(req_valid[i])
    );
  end
  assign src_active = |req_valid || sw_rst;
  always_ff @(posedge clk)
    if (reset) begin
      state <= ASSERT;
      hold_cnt <= '0;
      step_cnt <= '0;
      idx <= '0;
      rst_out_b <= '0;
      all_released <= 1'b0;
      busy <= 1'b1;
      rst_cause <= '0;
      req_valid_q <= '0;
    end else begin
      req_valid_q <= req_valid;
      // A clear on the same edge as a new source keeps only the newly set bits
      rst_cause <= (cause_clr ? '0 : rst_cause) | {sw_rst, req_valid & ~req_valid_q};
      if (src_active) begin
        state <= ASSERT;
        hold_cnt <= '0;
        step_cnt <= '0;
        idx <= '0;
        rst_out_b <= '0;
        all_released <= 1'b0;
        busy <= 1'b1;
      end else
        case (state)
          ASSERT:
            if (hold_cnt == CW'(HOLD_CYCLES - 1)) begin
              rst_out_b <= N_CH'(1);
              idx <= IW'(1);
              hold_cnt <= '0;
              state <= N_CH == 1 ? DONE : RELEASE;
              all_released <= N_CH == 1;
              busy <= N_CH != 1;
            end else
              hold_cnt <= hold_cnt + 1'b1;
          RELEASE:
            if (step_cnt == CW'(STEP_CYCLES - 1)) begin
              rst_out_b <= rst_out_b | (N_CH'(1) << idx);
              idx <= idx + 1'b1;
              step_cnt <= '0;
              if (idx == IW'(N_CH - 1)) begin
                state <= DONE;
                all_released <= 1'b1;
                busy <= 1'b0;
              end
            end else
              step_cnt <= step_cnt + 1'b1;
          default: ;
        endcase
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scoreboard bench for a default sequencer and a single-channel fast one
module tb_reset_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1, sw_rst = 1'b0, cause_clr = 1'b0;
  logic [1:0] rst_req_b = 2'b11;
  logic [2:0] rst_out_b;
  logic all_released, busy;
  logic [2:0] rst_cause;
  logic reset1 = 1'b1, sw_rst1 = 1'b0, cause_clr1 = 1'b0;
  logic [1:0] req1 = 2'b11;
  logic [0:0] rob1;
  logic ar1, busy1;
  logic [2:0] cause1;
  reset_sequencer u_dut (
    .clk(clk), .reset(reset), .rst_req_b(rst_req_b), .sw_rst(sw_rst), .cause_clr(cause_clr),
    .rst_out_b(rst_out_b), .all_released(all_released), .busy(busy), .rst_cause(rst_cause)
  );
  reset_sequencer #(.N_CH(1), .HOLD_CYCLES(1), .STEP_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset1), .rst_req_b(req1), .sw_rst(sw_rst1), .cause_clr(cause_clr1),
    .rst_out_b(rob1), .all_released(ar1), .busy(busy1), .rst_cause(cause1)
  );
  typedef struct {
    int cyc;
    int id;
    string tag;
    logic [7:0] exp;
  } exp_t;
  exp_t sb[$];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  function automatic logic [7:0] pk(input logic [2:0] r, input logic a, input logic b, input logic [2:0] c);
    return {r, a, b, c};
  endfunction
  function automatic logic [7:0] obs(input int id);
    return id != 0 ? {2'b00, rob1, ar1, busy1, cause1} : {rst_out_b, all_released, busy, rst_cause};
  endfunction
  task automatic push(input int dly, input int id, input string tag, input logic [7:0] e);
    sb.push_back('{cyc + dly, id, tag, e});
  endtask
  // Expected word layout: {rst_out_b[2:0], all_released, busy, rst_cause[2:0]}
  task automatic tick(input int n);
    exp_t e;
    logic [7:0] o;
    repeat (n) begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        o = obs(e.id);
        vectors++;
        assert (o === e.exp && e.cyc == cyc) else begin
          miscompares++;
          $error("FAIL %s: got %b expected %b (cycle %0d due %0d)", e.tag, o, e.exp, cyc, e.cyc);
        end
      end
    end
  endtask
  initial begin
    push(1, 0, "rst", pk(3'b000, 0, 1, 3'b000));
    push(1, 1, "rst1", pk(3'b000, 0, 1, 3'b000));
    tick(5);
    reset = 1'b0;
    push(3, 0, "t1_e3", pk(3'b000, 0, 1, 3'b000));
    push(4, 0, "t1_e4", pk(3'b001, 0, 1, 3'b000));
    push(5, 0, "t1_e5", pk(3'b001, 0, 1, 3'b000));
    push(6, 0, "t1_e6", pk(3'b011, 0, 1, 3'b000));
    push(7, 0, "t1_e7", pk(3'b011, 0, 1, 3'b000));
    push(8, 0, "t1_e8", pk(3'b111, 1, 0, 3'b000));
    tick(8);
    rst_req_b[1] = 1'b0;
    tick(1);
    rst_req_b[1] = 1'b1;
    push(2, 0, "t2_glitch_a", pk(3'b111, 1, 0, 3'b000));
    push(6, 0, "t2_glitch_b", pk(3'b111, 1, 0, 3'b000));
    tick(6);
    rst_req_b[0] = 1'b0;
    push(2, 0, "t3_pre", pk(3'b111, 1, 0, 3'b000));
    push(5, 0, "t3_assert", pk(3'b000, 0, 1, 3'b001));
    push(6, 0, "t3_held", pk(3'b000, 0, 1, 3'b001));
    tick(6);
    rst_req_b[0] = 1'b1;
    push(5, 0, "t3_hold", pk(3'b000, 0, 1, 3'b001));
    push(6, 0, "t3_b0", pk(3'b001, 0, 1, 3'b001));
    push(8, 0, "t3_b1", pk(3'b011, 0, 1, 3'b001));
    push(10, 0, "t3_done", pk(3'b111, 1, 0, 3'b001));
    tick(10);
    cause_clr = 1'b1;
    push(1, 0, "clr", pk(3'b111, 1, 0, 3'b000));
    tick(1);
    cause_clr = 1'b0;
    sw_rst = 1'b1;
    push(1, 0, "t4_sw", pk(3'b000, 0, 1, 3'b100));
    tick(1);
    sw_rst = 1'b0;
    push(4, 0, "t4_b0", pk(3'b001, 0, 1, 3'b100));
    push(5, 0, "t4_pre_clash", pk(3'b001, 0, 1, 3'b100));
    tick(5);
    sw_rst = 1'b1;
    push(1, 0, "t4_clash", pk(3'b000, 0, 1, 3'b100));
    tick(1);
    sw_rst = 1'b0;
    push(3, 0, "t4_rehold", pk(3'b000, 0, 1, 3'b100));
    push(4, 0, "t4_re_b0", pk(3'b001, 0, 1, 3'b100));
    push(6, 0, "t4_re_b1", pk(3'b011, 0, 1, 3'b100));
    push(8, 0, "t4_re_done", pk(3'b111, 1, 0, 3'b100));
    tick(8);
    sw_rst = 1'b1;
    push(1, 0, "t5_sw", pk(3'b000, 0, 1, 3'b100));
    tick(1);
    sw_rst = 1'b0;
    push(4, 0, "t5_b0", pk(3'b001, 0, 1, 3'b100));
    tick(4);
    reset = 1'b1;
    push(1, 0, "t5_rst", pk(3'b000, 0, 1, 3'b000));
    tick(1);
    reset = 1'b0;
    push(4, 0, "t5_b0_again", pk(3'b001, 0, 1, 3'b000));
    push(8, 0, "t5_done", pk(3'b111, 1, 0, 3'b000));
    tick(8);
    reset1 = 1'b0;
    push(1, 1, "t6_e1", pk(3'b001, 1, 0, 3'b000));
    tick(1);
    req1[0] = 1'b0;
    push(5, 1, "t6_req", pk(3'b000, 0, 1, 3'b001));
    tick(5);
    req1[0] = 1'b1;
    push(2, 1, "t6_hold", pk(3'b000, 0, 1, 3'b001));
    push(3, 1, "t6_rel", pk(3'b001, 1, 0, 3'b001));
    tick(3);
    cause_clr1 = 1'b1;
    sw_rst1 = 1'b1;
    push(1, 1, "t6_clr_sw", pk(3'b000, 0, 1, 3'b100));
    tick(1);
    cause_clr1 = 1'b0;
    sw_rst1 = 1'b0;
    push(1, 1, "t6_end", pk(3'b001, 1, 0, 3'b100));
    tick(3);
    while (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: never checked, due cycle %0d", sb[0].tag, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
